// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS main controller: sequences the shared datapath per instruction.
// Optional performance counters are enabled by defining MC_PERF_CNT_EN.
module mc_ctrl_fsm #(
    parameter int         WAIT_LIMIT = 16,
    parameter logic [1:0] RA_SEL     = 2'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_we,
    output logic       ir_we,
    output logic       iord,
    output logic       mem_re,
    output logic       mem_we,
    output logic       reg_we,
    output logic [1:0] reg_dst,
    output logic [1:0] wd_sel,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic       ext_sign,
    output logic [1:0] pc_src,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal,
    output logic       mem_timeout
`ifdef MC_PERF_CNT_EN
    ,
    output logic [31:0] cyc_cnt,
    output logic [31:0] inst_cnt
`endif
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        JR     = 4'd10
    } state_t;

    localparam logic [15:0] LIMIT = 16'(WAIT_LIMIT);

    state_t      cur;
    state_t      nxt;
    logic [15:0] wait_cnt;
    logic        waiting;

    logic is_rtype, is_addu, is_subu, is_jr;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;

    // The IR holds op/func stable from DECODE onward, so later states decode them directly.
    assign is_rtype = (op == 6'b000000);
    assign is_addu  = is_rtype && (func == 6'b100001);
    assign is_subu  = is_rtype && (func == 6'b100011);
    assign is_jr    = is_rtype && (func == 6'b001000);
    assign is_ori   = (op == 6'b001101);
    assign is_lui   = (op == 6'b001111);
    assign is_lw    = (op == 6'b100011);
    assign is_sw    = (op == 6'b101011);
    assign is_beq   = (op == 6'b000100);
    assign is_j     = (op == 6'b000010);
    assign is_jal   = (op == 6'b000011);

    assign waiting = ((cur == FETCH) || (cur == MEMRD) || (cur == MEMWR)) && !mem_ready;
    assign state   = reset ? 4'(cur) : 4'd0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur         <= FETCH;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            cur <= nxt;
            if (waiting) begin
                if (wait_cnt != 16'hFFFF)
                    wait_cnt <= wait_cnt + 16'd1;
                if ((LIMIT != 16'd0) && (wait_cnt + 16'd1 == LIMIT))
                    mem_timeout <= 1'b1;
            end else begin
                wait_cnt <= '0;
            end
        end
    end

    // Outputs are Mealy on mem_ready/zero and forced to zero while reset is asserted.
    always_comb begin
        nxt        = cur;
        pc_we      = 1'b0;
        ir_we      = 1'b0;
        iord       = 1'b0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 2'd0;
        wd_sel     = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_ctrl   = 3'd0;
        ext_sign   = 1'b0;
        pc_src     = 2'd0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (reset) begin
            case (cur)
                FETCH: begin
                    mem_re = 1'b1;
                    if (mem_ready) begin
                        ir_we     = 1'b1;
                        pc_we     = 1'b1;
                        alu_src_b = 2'd1;
                        nxt       = DECODE;
                    end
                end
                DECODE: begin
                    alu_src_b = 2'd3;
                    if (is_addu || is_subu || is_ori || is_lui) nxt = EXEC;
                    else if (is_lw || is_sw)                    nxt = MEMADR;
                    else if (is_beq)                            nxt = BRANCH;
                    else if (is_j || is_jal)                    nxt = JUMP;
                    else if (is_jr)                             nxt = JR;
                    else begin
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                        nxt        = FETCH;
                    end
                end
                EXEC: begin
                    if (is_ori) begin
                        alu_src_b = 2'd2;
                        alu_ctrl  = 3'd2;
                    end else if (is_lui) begin
                        alu_src_b = 2'd2;
                        alu_ctrl  = 3'd3;
                    end else begin
                        alu_src_a = 1'b1;
                        alu_ctrl  = is_subu ? 3'd1 : 3'd0;
                    end
                    nxt = ALUWB;
                end
                ALUWB: begin
                    reg_we     = 1'b1;
                    reg_dst    = is_rtype ? 2'd1 : 2'd0;
                    instr_done = 1'b1;
                    nxt        = FETCH;
                end
                MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    ext_sign  = 1'b1;
                    nxt       = is_sw ? MEMWR : MEMRD;
                end
                MEMRD: begin
                    mem_re = 1'b1;
                    iord   = 1'b1;
                    if (mem_ready) nxt = MEMWB;
                end
                MEMWB: begin
                    reg_we     = 1'b1;
                    wd_sel     = 2'd1;
                    instr_done = 1'b1;
                    nxt        = FETCH;
                end
                MEMWR: begin
                    mem_we = 1'b1;
                    iord   = 1'b1;
                    if (mem_ready) begin
                        instr_done = 1'b1;
                        nxt        = FETCH;
                    end
                end
                BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_ctrl   = 3'd1;
                    pc_src     = 2'd1;
                    pc_we      = zero;
                    instr_done = 1'b1;
                    nxt        = FETCH;
                end
                JUMP: begin
                    pc_src     = 2'd2;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                    if (is_jal) begin
                        reg_we  = 1'b1;
                        reg_dst = RA_SEL;
                        wd_sel  = 2'd2;
                    end
                    nxt = FETCH;
                end
                JR: begin
                    pc_src     = 2'd3;
                    pc_we      = 1'b1;
                    instr_done = 1'b1;
                    nxt        = FETCH;
                end
                default: nxt = FETCH;
            endcase
        end
    end

`ifdef MC_PERF_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_cnt  <= '0;
            inst_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 32'd1;
            if (instr_done)
                inst_cnt <= inst_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Self-checking bench for mc_ctrl_fsm: directed table, corner sequences, random run against
// a path-based reference model. Define MC_PERF_CNT_EN to also check the perf counters.
module tb_mc_ctrl_fsm;

    localparam int WL = 4;

    localparam int C_ADDU = 0, C_SUBU = 1, C_ORI = 2, C_LUI = 3, C_LW = 4, C_SW = 5;
    localparam int C_BEQ = 6, C_J = 7, C_JAL = 8, C_JR = 9, C_ILL = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] func = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic       pc_we, ir_we, iord, mem_re, mem_we, reg_we;
    logic [1:0] reg_dst, wd_sel, alu_src_b, pc_src;
    logic       alu_src_a, ext_sign, instr_done, illegal, mem_timeout;
    logic [2:0] alu_ctrl;
    logic [3:0] state;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cyc_cnt, inst_cnt;
`endif

    typedef struct packed {
        logic       pc_we;
        logic       ir_we;
        logic       iord;
        logic       mem_re;
        logic       mem_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic       ext_sign;
        logic [1:0] pc_src;
        logic [3:0] state;
        logic       instr_done;
        logic       illegal;
    } outs_t;

    outs_t act;
    assign act = {pc_we, ir_we, iord, mem_re, mem_we, reg_we, reg_dst, wd_sel, alu_src_a,
                  alu_src_b, alu_ctrl, ext_sign, pc_src, state, instr_done, illegal};

    mc_ctrl_fsm #(.WAIT_LIMIT(WL), .RA_SEL(2'd2)) dut (
        .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .ir_we(ir_we), .iord(iord), .mem_re(mem_re), .mem_we(mem_we),
        .reg_we(reg_we), .reg_dst(reg_dst), .wd_sel(wd_sel), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .ext_sign(ext_sign), .pc_src(pc_src),
        .state(state), .instr_done(instr_done), .illegal(illegal), .mem_timeout(mem_timeout)
`ifdef MC_PERF_CNT_EN
        , .cyc_cnt(cyc_cnt), .inst_cnt(inst_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: the list of states an instruction visits, plus wait/timeout bookkeeping.
    int m_path[$];
    int m_idx;
    int m_cls;
    int m_cnt;
    logic m_to;

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, got, want);
        end
    endtask

    function automatic int classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b000000: begin
                if (f == 6'b100001) return C_ADDU;
                if (f == 6'b100011) return C_SUBU;
                if (f == 6'b001000) return C_JR;
                return C_ILL;
            end
            6'b001101: return C_ORI;
            6'b001111: return C_LUI;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b000010: return C_J;
            6'b000011: return C_JAL;
            default:   return C_ILL;
        endcase
    endfunction

    task automatic start_model(input int cls);
        m_cls = cls;
        m_idx = 0;
        m_path.delete();
        m_path.push_back(0);
        m_path.push_back(1);
        case (cls)
            C_ADDU, C_SUBU, C_ORI, C_LUI: begin m_path.push_back(6); m_path.push_back(7); end
            C_LW:       begin m_path.push_back(2); m_path.push_back(3); m_path.push_back(4); end
            C_SW:       begin m_path.push_back(2); m_path.push_back(5); end
            C_BEQ:      m_path.push_back(8);
            C_J, C_JAL: m_path.push_back(9);
            C_JR:       m_path.push_back(10);
            default:    ;
        endcase
    endtask

    function automatic outs_t exp_out(input int st, input int cls, input logic z, input logic mr);
        outs_t o;
        o = '0;
        o.state = 4'(st);
        case (st)
            0: begin
                o.mem_re = 1'b1;
                if (mr) begin o.ir_we = 1'b1; o.pc_we = 1'b1; o.alu_src_b = 2'd1; end
            end
            1: begin
                o.alu_src_b = 2'd3;
                if (cls == C_ILL) begin o.illegal = 1'b1; o.instr_done = 1'b1; end
            end
            2: begin o.alu_src_a = 1'b1; o.alu_src_b = 2'd2; o.ext_sign = 1'b1; end
            3: begin o.mem_re = 1'b1; o.iord = 1'b1; end
            4: begin o.reg_we = 1'b1; o.wd_sel = 2'd1; o.instr_done = 1'b1; end
            5: begin o.mem_we = 1'b1; o.iord = 1'b1; o.instr_done = mr; end
            6: begin
                if (cls == C_ADDU) o.alu_src_a = 1'b1;
                if (cls == C_SUBU) begin o.alu_src_a = 1'b1; o.alu_ctrl = 3'd1; end
                if (cls == C_ORI)  begin o.alu_src_b = 2'd2; o.alu_ctrl = 3'd2; end
                if (cls == C_LUI)  begin o.alu_src_b = 2'd2; o.alu_ctrl = 3'd3; end
            end
            7: begin
                o.reg_we = 1'b1;
                o.reg_dst = (cls == C_ADDU || cls == C_SUBU) ? 2'd1 : 2'd0;
                o.instr_done = 1'b1;
            end
            8: begin
                o.alu_src_a = 1'b1; o.alu_ctrl = 3'd1; o.pc_src = 2'd1;
                o.pc_we = z; o.instr_done = 1'b1;
            end
            9: begin
                o.pc_src = 2'd2; o.pc_we = 1'b1; o.instr_done = 1'b1;
                if (cls == C_JAL) begin o.reg_we = 1'b1; o.reg_dst = 2'd2; o.wd_sel = 2'd2; end
            end
            10: begin o.pc_src = 2'd3; o.pc_we = 1'b1; o.instr_done = 1'b1; end
            default: ;
        endcase
        return o;
    endfunction

    // One clock cycle: drive inputs, compare mid-cycle, advance the model at the edge.
    task automatic apply_stimulus(input logic mr, input logic z);
        int st;
        outs_t e;
        mem_ready = mr;
        zero = z;
        @(negedge clk);
        st = m_path[m_idx];
        e = exp_out(st, m_cls, z, mr);
        check_output($sformatf("outputs st=%0d cls=%0d", st, m_cls), 32'(act), 32'(e));
        check_output("mem_timeout", 32'(mem_timeout), 32'(m_to));
        if ((st == 0 || st == 3 || st == 5) && !mr) begin
            m_cnt++;
            if (m_cnt == WL) m_to = 1'b1;
        end else begin
            m_cnt = 0;
            m_idx++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                             input bit rnd, output int cyc);
        op = o;
        func = f;
        start_model(classify(o, f));
        cyc = 0;
        while (m_idx < m_path.size() && cyc < 100) begin
            apply_stimulus(rnd ? logic'($urandom_range(0, 3) != 0) : 1'b1, z);
            cyc++;
        end
        if (m_idx < m_path.size()) begin
            failures++;
            $display("[TB] FAIL cycle_budget actual=%0d required<100", cyc);
        end
    endtask

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] func;
        logic       z;
        int         cycles;
    } vec_t;

    vec_t vecs[12];
    logic [5:0] legal_op[10] = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h00};
    logic [5:0] legal_fn[10] = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08};

    initial begin
        int cyc;
        int k;
        logic [5:0] ro, rf;

        vecs[0]  = '{"addu",    6'b000000, 6'b100001, 1'b0, 4};
        vecs[1]  = '{"lw",      6'b100011, 6'b000000, 1'b0, 5};
        vecs[2]  = '{"sw",      6'b101011, 6'b000000, 1'b0, 4};
        vecs[3]  = '{"subu",    6'b000000, 6'b100011, 1'b0, 4};
        vecs[4]  = '{"ori",     6'b001101, 6'b010101, 1'b0, 4};
        vecs[5]  = '{"lui",     6'b001111, 6'b000000, 1'b0, 4};
        vecs[6]  = '{"beq_t",   6'b000100, 6'b000000, 1'b1, 3};
        vecs[7]  = '{"beq_nt",  6'b000100, 6'b000000, 1'b0, 3};
        vecs[8]  = '{"j",       6'b000010, 6'b000000, 1'b0, 3};
        vecs[9]  = '{"jal",     6'b000011, 6'b000000, 1'b0, 3};
        vecs[10] = '{"jr",      6'b000000, 6'b001000, 1'b0, 3};
        vecs[11] = '{"illegal", 6'b111111, 6'b000000, 1'b0, 2};

        m_to = 1'b0;
        m_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            check_output("reset_outputs", 32'(act), 32'd0);
            check_output("reset_timeout", 32'(mem_timeout), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;

        foreach (vecs[i]) begin
            run_instr(vecs[i].op, vecs[i].func, vecs[i].z, 1'b0, cyc);
            check_output({vecs[i].name, "_cycles"}, 32'(cyc), 32'(vecs[i].cycles));
        end

        // lw stalled 6 cycles in MEMRD: timeout rises after the 4th wait and stays set.
        op = 6'b100011;
        func = 6'b000000;
        start_model(C_LW);
        repeat (3) apply_stimulus(1'b1, 1'b0);
        for (k = 1; k <= 6; k++) begin
            apply_stimulus(1'b0, 1'b0);
            check_output($sformatf("timeout_after_wait%0d", k), 32'(mem_timeout), 32'(k >= WL));
        end
        apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b1, 1'b0);
        check_output("timeout_sticky", 32'(mem_timeout), 32'd1);

        // Reset while waiting in MEMRD: access abandoned, no reg_we, restart at FETCH.
        start_model(C_LW);
        repeat (3) apply_stimulus(1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0);
        mem_ready = 1'b1;
        reset = 1'b0;
        #1;
        check_output("midrd_reset_outputs", 32'(act), 32'd0);
        @(negedge clk);
        check_output("midrd_reset_reg_we", 32'(reg_we), 32'd0);
        check_output("midrd_reset_timeout", 32'(mem_timeout), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        m_to = 1'b0;
        m_cnt = 0;
        start_model(C_LW);
        while (m_idx < m_path.size()) apply_stimulus(1'b1, 1'b0);

        // Random instruction mix with random memory stalls.
        for (int n = 0; n < 150; n++) begin
            k = $urandom_range(0, 9);
            ro = legal_op[k];
            rf = legal_fn[k];
            if ($urandom_range(0, 7) == 0) begin
                ro = 6'($urandom);
                rf = 6'($urandom);
            end
            run_instr(ro, rf, logic'($urandom_range(0, 1)), 1'b1, cyc);
        end

`ifdef MC_PERF_CNT_EN
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        m_to = 1'b0;
        m_cnt = 0;
        for (int n = 0; n < 10; n++) run_instr(6'b000000, 6'b100001, 1'b0, 1'b0, cyc);
        check_output("inst_cnt", inst_cnt, 32'd10);
        check_output("cyc_cnt", cyc_cnt, 32'd40);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
